// File: rtl/hangman_engine.sv
// rtl/hangman_engine.sv - hangman guess-evaluation engine
// Compares each fresh guess serially against the latched word, one position per cycle.
module hangman_engine #(
  parameter int WORD_LEN   = 5,
  parameter int MAX_MISSES = 6
) (
  input  logic                             clk,
  input  logic                             nRst,
  input  logic                             word_load,
  input  logic [8*WORD_LEN-1:0]            set_word,
  input  logic                             guess_valid,
  input  logic [7:0]                       guess,
  output logic                             guess_ready,
  output logic                             result_valid,
  output logic                             hit,
  output logic                             repeat_guess,
  output logic                             invalid,
  output logic [WORD_LEN-1:0]              match_mask,
  output logic [WORD_LEN-1:0]              revealed,
  output logic [$clog2(MAX_MISSES+1)-1:0]  miss_count,
  output logic                             game_over,
  output logic                             win
);

  localparam int MC_W  = $clog2(MAX_MISSES + 1);
  localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [MC_W-1:0]  MISS_MAX = MC_W'(MAX_MISSES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_CHECK,
    S_REPORT,
    S_DONE
  } state_t;

  state_t                state, state_nx;
  logic [8*WORD_LEN-1:0] word_q;
  logic [25:0]           history;
  logic [25:0]           letter_bit;
  logic [7:0]            guess_q;
  logic [IDX_W-1:0]      idx;
  logic [WORD_LEN-1:0]   load_revealed;
  logic [WORD_LEN-1:0]   final_mask;
  logic                  guess_alpha;
  logic                  guess_seen;
  logic                  pos_eq;
  logic                  last_pos;

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  // Non-letters (padding spaces) are shown from the start of the round.
  always_comb begin
    load_revealed = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      load_revealed[i] = !is_letter(set_word[8*i +: 8]);
    end
  end

  always_comb begin
    letter_bit = '0;
    for (int k = 0; k < 26; k++) begin
      letter_bit[k] = (guess == 8'(8'h41 + k));
    end
  end

  assign guess_alpha = is_letter(guess);
  assign guess_seen  = |(history & letter_bit);
  assign pos_eq      = (word_q[8*idx +: 8] == guess_q);
  assign last_pos    = (idx == LAST_IDX);
  assign final_mask  = match_mask | (pos_eq ? (WORD_LEN'(1) << idx) : '0);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (word_load) begin
      state_nx = (&load_revealed) ? S_DONE : S_PLAY;
    end else begin
      case (state)
        S_PLAY: begin
          if (guess_valid) begin
            state_nx = (!guess_alpha || guess_seen) ? S_REPORT : S_CHECK;
          end
        end
        S_CHECK: begin
          if (last_pos) begin
            state_nx = S_REPORT;
          end
        end
        S_REPORT: begin
          if ((&revealed) || (miss_count == MISS_MAX)) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_PLAY;
          end
        end
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    guess_ready  = (state == S_PLAY);
    result_valid = (state == S_REPORT);
    game_over    = (state == S_DONE);
  end

  // Result fields land on the last CHECK cycle so they are valid alongside result_valid.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      word_q       <= '0;
      history      <= '0;
      guess_q      <= '0;
      idx          <= '0;
      match_mask   <= '0;
      revealed     <= '0;
      miss_count   <= '0;
      hit          <= 1'b0;
      repeat_guess <= 1'b0;
      invalid      <= 1'b0;
      win          <= 1'b0;
    end else if (word_load) begin
      word_q       <= set_word;
      history      <= '0;
      idx          <= '0;
      match_mask   <= '0;
      revealed     <= load_revealed;
      miss_count   <= '0;
      hit          <= 1'b0;
      repeat_guess <= 1'b0;
      invalid      <= 1'b0;
      win          <= &load_revealed;
    end else begin
      case (state)
        S_PLAY: begin
          if (guess_valid) begin
            guess_q      <= guess;
            idx          <= '0;
            match_mask   <= '0;
            hit          <= 1'b0;
            repeat_guess <= 1'b0;
            invalid      <= 1'b0;
            if (!guess_alpha) begin
              invalid <= 1'b1;
            end else if (guess_seen) begin
              repeat_guess <= 1'b1;
            end else begin
              history <= history | letter_bit;
            end
          end
        end
        S_CHECK: begin
          match_mask <= final_mask;
          idx        <= idx + 1'b1;
          if (last_pos) begin
            revealed <= revealed | final_mask;
            if (final_mask == '0) begin
              if (miss_count != MISS_MAX) begin
                miss_count <= miss_count + 1'b1;
              end
            end else begin
              hit <= 1'b1;
            end
          end
        end
        S_REPORT: begin
          if (&revealed) begin
            win <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
